// File: rtl/secded_pkg.sv
// secded_pkg: shared widths, FSM states and data-extraction helper for the SECDED decoder.
package secded_pkg;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_DEC, S_WR, S_NEXT, S_DONE} state_e;

    function automatic int n_of(input int r);
        return 1 << r;
    endfunction

    function automatic int dw_of(input int r);
        return (1 << r) - r - 1;
    endfunction

    function automatic int b_of(input int r);
        return (1 << r) / 8;
    endfunction

    function automatic int flag_dbl(input int r);
        return (1 << r) - 1;
    endfunction

    function automatic int flag_sgl(input int r);
        return (1 << r) - 2;
    endfunction

    // Data bits live at every non-power-of-two position above 0, packed ascending.
    function automatic logic [31:0] secded_extract(input logic [31:0] cw, input int r);
        logic [31:0] d;
        int k;
        d = '0;
        k = 0;
        for (int i = 1; i < 32; i++) begin
            if (i < (1 << r) && (i & (i - 1)) != 0) begin
                d[k[4:0]] = cw[i];
                k++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/secded_word_decode.sv
// secded_word_decode: combinational Hamming SECDED decode of one codeword.
module secded_word_decode
    import secded_pkg::*;
#(
    parameter int R = 4
) (
    input  logic [n_of(R)-1:0]  cw_i,
    output logic [dw_of(R)-1:0] data_o,
    output logic [1:0]          flags_o,
    output logic [R-1:0]        syn_o
);

    localparam int N  = n_of(R);
    localparam int DW = dw_of(R);

    logic         p;
    logic [N-1:0] fixed;

    always_comb begin
        syn_o = '0;
        for (int i = 1; i < N; i++) syn_o ^= cw_i[i] ? R'(i) : '0;
        p = ^cw_i;
        // A zero syndrome with odd parity flips p0 only, leaving data intact.
        fixed = p ? cw_i ^ (N'(1) << syn_o) : cw_i;
        flags_o = {~p && (syn_o != '0), p};
        data_o = DW'(secded_extract(32'(fixed), R));
    end

endmodule

// File: rtl/secded_mem_decoder.sv
// secded_mem_decoder: walks COUNT codewords in byte memory, SECDED-decodes each and
// writes {flags, data} result words to the destination region with per-run error counts.
module secded_mem_decoder
    import secded_pkg::*;
#(
    parameter int R        = 4,
    parameter int AW       = 8,
    parameter int COUNT    = 15,
    parameter int SRC_BASE = 30,
    parameter int DST_BASE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       done,
    output logic [AW-1:0]              mem_addr,
    output logic                       mem_rd_en,
    input  logic [7:0]                 mem_rd_data,
    output logic                       mem_wr_en,
    output logic [7:0]                 mem_wr_data,
    output logic [$clog2(COUNT+1)-1:0] err1_cnt,
    output logic [$clog2(COUNT+1)-1:0] err2_cnt
);

    localparam int N  = n_of(R);
    localparam int DW = dw_of(R);
    localparam int B  = b_of(R);
    localparam int CW = $clog2(COUNT + 1);
    localparam int JW = 3;

    state_e          state_q, state_d;
    logic [JW-1:0]   j_q, j_d;
    logic [CW-1:0]   idx_q, idx_d, e1_q, e1_d, e2_q, e2_d;
    logic [N-1:0]    cw_q, cw_d, res_q, res_d;
    logic [DW-1:0]   dec_data;
    logic [1:0]      dec_flags;
    logic [R-1:0]    dec_syn_unused;

    secded_word_decode #(.R(R)) u_dec (
        .cw_i   (cw_q),
        .data_o (dec_data),
        .flags_o(dec_flags),
        .syn_o  (dec_syn_unused)
    );

    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        idx_d       = idx_q;
        e1_d        = e1_q;
        e2_d        = e2_q;
        cw_d        = cw_q;
        res_d       = res_q;
        mem_addr    = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RD;
                    j_d     = '0;
                    idx_d   = '0;
                    e1_d    = '0;
                    e2_d    = '0;
                end
            end
            // j counts B read cycles then one extra cycle to capture the last byte.
            S_RD: begin
                mem_rd_en = j_q != JW'(B);
                mem_addr  = mem_rd_en ? AW'(SRC_BASE + B * int'(idx_q) + int'(j_q)) : '0;
                for (int b = 0; b < B; b++) if (j_q == JW'(b + 1)) cw_d[8*b +: 8] = mem_rd_data;
                j_d       = j_q + 1'b1;
                if (j_q == JW'(B)) begin
                    state_d = S_DEC;
                    j_d     = '0;
                end
            end
            S_DEC: begin
                res_d           = '0;
                res_d[N-1]      = dec_flags[1];
                res_d[N-2]      = dec_flags[0];
                res_d[DW-1:0]   = dec_data;
                e1_d            = (dec_flags[0] && e1_q != CW'(COUNT)) ? e1_q + 1'b1 : e1_q;
                e2_d            = (dec_flags[1] && e2_q != CW'(COUNT)) ? e2_q + 1'b1 : e2_q;
                state_d         = S_WR;
            end
            S_WR: begin
                mem_wr_en = 1'b1;
                mem_addr  = AW'(DST_BASE + B * int'(idx_q) + int'(j_q));
                for (int b = 0; b < B; b++) if (j_q == JW'(b)) mem_wr_data = res_q[8*b +: 8];
                j_d       = j_q + 1'b1;
                if (j_q == JW'(B - 1)) begin
                    state_d = S_NEXT;
                    j_d     = '0;
                end
            end
            S_NEXT: begin
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == CW'(COUNT - 1)) ? S_DONE : S_RD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            idx_q   <= '0;
            e1_q    <= '0;
            e2_q    <= '0;
            cw_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            idx_q   <= idx_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            cw_q    <= cw_d;
            res_q   <= res_d;
        end
    end

    assign done     = state_q == S_DONE;
    assign err1_cnt = e1_q;
    assign err2_cnt = e2_q;

endmodule

// File: tb/tb_secded_mem_decoder.sv
// tb_secded_mem_decoder: drives four decoder configurations against byte memories and
// compares result words and counters with an encode/inject reference model.
module tb_secded_mem_decoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    localparam int RV [4] = '{4, 4, 3, 5};

    logic [3:0] start_v = '0;
    logic [3:0] done_v, rd_v, wr_v;
    logic [7:0] addr_v [4];
    logic [7:0] rdd_v  [4];
    logic [7:0] wrd_v  [4];
    logic       c0_1, c0_2;
    logic [3:0] c1_1, c1_2;
    logic [1:0] c2_1, c2_2, c3_1, c3_2;
    logic [7:0] mem [4][256];
    logic [31:0] exp_w [4][16];
    int wr_cnt [4] = '{default: 0};
    int overlap = 0;
    int n1 [4], n2 [4], e1 [4], e2 [4];
    int checks = 0, errors = 0;

    secded_mem_decoder #(.R(4), .COUNT(1)) u_r4c1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .done(done_v[0]),
        .mem_addr(addr_v[0]), .mem_rd_en(rd_v[0]), .mem_rd_data(rdd_v[0]),
        .mem_wr_en(wr_v[0]), .mem_wr_data(wrd_v[0]), .err1_cnt(c0_1), .err2_cnt(c0_2));
    secded_mem_decoder #(.R(4), .COUNT(15)) u_r4c15 (
        .clk(clk), .reset(reset), .start(start_v[1]), .done(done_v[1]),
        .mem_addr(addr_v[1]), .mem_rd_en(rd_v[1]), .mem_rd_data(rdd_v[1]),
        .mem_wr_en(wr_v[1]), .mem_wr_data(wrd_v[1]), .err1_cnt(c1_1), .err2_cnt(c1_2));
    secded_mem_decoder #(.R(3), .COUNT(3)) u_r3c3 (
        .clk(clk), .reset(reset), .start(start_v[2]), .done(done_v[2]),
        .mem_addr(addr_v[2]), .mem_rd_en(rd_v[2]), .mem_rd_data(rdd_v[2]),
        .mem_wr_en(wr_v[2]), .mem_wr_data(wrd_v[2]), .err1_cnt(c2_1), .err2_cnt(c2_2));
    secded_mem_decoder #(.R(5), .COUNT(3)) u_r5c3 (
        .clk(clk), .reset(reset), .start(start_v[3]), .done(done_v[3]),
        .mem_addr(addr_v[3]), .mem_rd_en(rd_v[3]), .mem_rd_data(rdd_v[3]),
        .mem_wr_en(wr_v[3]), .mem_wr_data(wrd_v[3]), .err1_cnt(c3_1), .err2_cnt(c3_2));

    always_comb begin
        e1[0] = int'(c0_1); e2[0] = int'(c0_2);
        e1[1] = int'(c1_1); e2[1] = int'(c1_2);
        e1[2] = int'(c2_1); e2[2] = int'(c2_2);
        e1[3] = int'(c3_1); e2[3] = int'(c3_2);
    end

    // Byte memories with one-cycle read latency.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_v[k]) begin
                mem[k][addr_v[k]] <= wrd_v[k];
                wr_cnt[k] <= wr_cnt[k] + 1;
            end
            if (rd_v[k]) rdd_v[k] <= mem[k][addr_v[k]];
            if (rd_v[k] && wr_v[k]) overlap <= overlap + 1;
        end
    end

    function automatic logic [31:0] enc(input logic [31:0] d, input int r);
        logic [31:0] c;
        int k, s;
        c = '0;
        k = 0;
        s = 0;
        for (int i = 3; i < (1 << r); i++) if ((i & (i - 1)) != 0) begin c[i] = d[k]; k++; end
        for (int i = 1; i < (1 << r); i++) if (c[i]) s ^= i;
        for (int b = 0; b < r; b++) c[1 << b] = s[b];
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] c, input int r);
        logic [31:0] d;
        int k;
        d = '0;
        k = 0;
        for (int i = 3; i < (1 << r); i++) if ((i & (i - 1)) != 0) begin d[k] = c[i]; k++; end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic fill(input int k);
        for (int a = 0; a < 30; a++) mem[k][a] = 8'hAA;
        n1[k] = 0;
        n2[k] = 0;
    endtask

    task automatic put(input int k, input int i, input logic [31:0] cw, input logic [31:0] expv, input int nerr);
        int b;
        b = (1 << RV[k]) / 8;
        for (int j = 0; j < b; j++) mem[k][30 + b * i + j] = cw[8*j +: 8];
        exp_w[k][i] = expv;
        if (nerr == 1) n1[k]++;
        if (nerr == 2) n2[k]++;
    endtask

    task automatic prep(input int k, input int i, input int nerr);
        int r, n, a, bb;
        logic [31:0] d, c, expv;
        r = RV[k];
        n = 1 << r;
        d = $urandom & ((32'(1) << (n - r - 1)) - 1);
        c = enc(d, r);
        a = $urandom_range(0, n - 1);
        bb = $urandom_range(0, n - 1);
        while (bb == a) bb = $urandom_range(0, n - 1);
        if (nerr >= 1) c[a] = ~c[a];
        if (nerr == 2) c[bb] = ~c[bb];
        expv = (nerr == 0) ? d : (nerr == 1) ? ((32'(1) << (n - 2)) | d) : ((32'(1) << (n - 1)) | ext(c, r));
        put(k, i, c, expv, nerr);
    endtask

    task automatic go(input int k, input int expc, input string tag);
        int n;
        n = 0;
        @(negedge clk) start_v[k] = 1'b1;
        @(negedge clk) start_v[k] = 1'b0;
        while (!done_v[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, expc);
    endtask

    task automatic verify(input int k, input int count, input string tag);
        int b;
        logic [31:0] w;
        b = (1 << RV[k]) / 8;
        for (int i = 0; i < count; i++) begin
            w = '0;
            for (int j = 0; j < b; j++) w |= 32'(mem[k][b * i + j]) << (8 * j);
            chk($sformatf("%s_w%0d", tag, i), w, exp_w[k][i]);
        end
        chk({tag, "_e1"}, e1[k], n1[k]);
        chk({tag, "_e2"}, e2[k], n2[k]);
    endtask

    initial begin
        int w0;
        repeat (2) @(negedge clk);
        chk("rst_done", done_v, 4'h0);
        chk("rst_rd_en", rd_v, 4'h0);
        chk("rst_wr_en", wr_v, 4'h0);
        chk("rst_addr", addr_v[1], 8'h00);
        chk("rst_wr_data", wrd_v[1], 8'h00);
        chk("rst_cnt", {c1_1, c1_2}, 8'h00);
        reset = 1'b0;

        fill(0); put(0, 0, 32'h000F, 32'h0001, 0);
        go(0, 7, "r4c1_clean_done"); verify(0, 1, "r4c1_clean");
        repeat (3) @(negedge clk);
        chk("r4c1_done_held", done_v[0], 1'b1);
        fill(0); put(0, 0, 32'h002F, 32'h4001, 1);
        go(0, 7, "r4c1_sgl_done"); verify(0, 1, "r4c1_sgl");
        fill(0); put(0, 0, 32'h000E, 32'h4001, 1);
        go(0, 7, "r4c1_p0_done"); verify(0, 1, "r4c1_p0");
        fill(0); put(0, 0, 32'h022F, 32'h8013, 2);
        go(0, 7, "r4c1_dbl_done"); verify(0, 1, "r4c1_dbl");

        fill(1);
        for (int i = 0; i < 15; i++) prep(1, i, $urandom_range(0, 2));
        @(negedge clk) start_v[1] = 1'b1;
        @(negedge clk) start_v[1] = 1'b0;
        repeat (25) @(negedge clk);
        chk("mid_wr_active", wr_v[1], 1'b1);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("mid_rst_wr_en", wr_v[1], 1'b0);
        w0 = wr_cnt[1];
        repeat (20) @(negedge clk);
        chk("mid_rst_no_writes", wr_cnt[1] - w0, 0);
        chk("mid_rst_done", done_v[1], 1'b0);
        chk("mid_rst_e1", e1[1], 0);

        fill(1);
        for (int i = 0; i < 15; i++) prep(1, i, $urandom_range(0, 2));
        go(1, 105, "r4c15_done"); verify(1, 15, "r4c15");

        fill(2); prep(2, 0, 0); prep(2, 1, 1); prep(2, 2, 2);
        go(2, 15, "r3_done"); verify(2, 3, "r3");
        fill(3); prep(3, 0, 0); prep(3, 1, 1); prep(3, 2, 2);
        go(3, 33, "r5_done"); verify(3, 3, "r5");

        chk("rd_wr_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
